// File: rtl/bus_dev_port.sv
// rtl/bus_dev_port.sv - bus-side device endpoint: TX queue toward the arbiter, ID-filtered RX queue toward the host
module bus_dev_port #(
    parameter int          pckg_sz   = 16,
    parameter int          depth     = 8,
    parameter logic [7:0]  id        = 8'h00,
    parameter logic [7:0]  broadcast = 8'hFF
) (
    input  logic                         clk,
    input  logic                         reset,
    input  logic                         pop,
    output logic                         pndng,
    output logic [pckg_sz-1:0]           D_pop,
    input  logic                         push,
    input  logic [pckg_sz-1:0]           D_push,
    input  logic                         tx_wr,
    input  logic [pckg_sz-1:0]           tx_data,
    output logic                         tx_full,
    input  logic                         rx_rd,
    output logic [pckg_sz-1:0]           rx_data,
    output logic                         rx_empty,
    output logic [$clog2(depth+1)-1:0]   tx_cnt,
    output logic [$clog2(depth+1)-1:0]   rx_cnt,
    output logic [7:0]                   tx_ovf_cnt,
    output logic [7:0]                   rx_ovf_cnt,
    output logic [7:0]                   rx_flt_cnt,
    output logic                         pop_err
);

    localparam int aw = $clog2(depth);
    localparam int cw = $clog2(depth+1);
    localparam logic [cw-1:0] full_cnt = cw'(depth);

    // TX queue
    logic [pckg_sz-1:0] tx_mem [depth];
    logic [aw-1:0]      tx_rd_ptr;
    logic [aw-1:0]      tx_wr_ptr;
    logic               tx_push;
    logic               tx_take;
    logic               tx_drop;

    assign tx_full = (tx_cnt == full_cnt);
    assign pndng   = (tx_cnt != '0);
    assign D_pop   = pndng ? tx_mem[tx_rd_ptr] : '0;
    // A pop while full frees the head slot on the same edge, so the write can land there
    assign tx_push = tx_wr && (!tx_full || pop);
    assign tx_drop = tx_wr && tx_full && !pop;
    assign tx_take = pop && pndng;

    always_ff @(posedge clk) begin
        if (tx_push) begin
            tx_mem[tx_wr_ptr] <= tx_data;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            tx_rd_ptr  <= '0;
            tx_wr_ptr  <= '0;
            tx_cnt     <= '0;
            tx_ovf_cnt <= '0;
            pop_err    <= 1'b0;
        end else begin
            if (tx_push) begin
                tx_wr_ptr <= tx_wr_ptr + aw'(1);
            end
            if (tx_take) begin
                tx_rd_ptr <= tx_rd_ptr + aw'(1);
            end
            case ({tx_push, tx_take})
                2'b10:   tx_cnt <= tx_cnt + cw'(1);
                2'b01:   tx_cnt <= tx_cnt - cw'(1);
                default: tx_cnt <= tx_cnt;
            endcase
            if (tx_drop && tx_ovf_cnt != 8'hFF) begin
                tx_ovf_cnt <= tx_ovf_cnt + 8'd1;
            end
            if (pop && !pndng) begin
                pop_err <= 1'b1;
            end
        end
    end

    // RX queue
    logic [pckg_sz-1:0] rx_mem [depth];
    logic [aw-1:0]      rx_rd_ptr;
    logic [aw-1:0]      rx_wr_ptr;
    logic [7:0]         dest;
    logic               match;
    logic               rx_full;
    logic               rx_push;
    logic               rx_take;
    logic               rx_drop;
    logic               rx_rej;

    assign dest     = D_push[pckg_sz-1 -: 8];
    assign match    = (dest == id) || (dest == broadcast);
    assign rx_full  = (rx_cnt == full_cnt);
    assign rx_empty = (rx_cnt == '0);
    assign rx_data  = rx_empty ? '0 : rx_mem[rx_rd_ptr];
    assign rx_push  = push && match && (!rx_full || rx_rd);
    assign rx_drop  = push && match && rx_full && !rx_rd;
    assign rx_rej   = push && !match;
    assign rx_take  = rx_rd && !rx_empty;

    always_ff @(posedge clk) begin
        if (rx_push) begin
            rx_mem[rx_wr_ptr] <= D_push;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rx_rd_ptr  <= '0;
            rx_wr_ptr  <= '0;
            rx_cnt     <= '0;
            rx_ovf_cnt <= '0;
            rx_flt_cnt <= '0;
        end else begin
            if (rx_push) begin
                rx_wr_ptr <= rx_wr_ptr + aw'(1);
            end
            if (rx_take) begin
                rx_rd_ptr <= rx_rd_ptr + aw'(1);
            end
            case ({rx_push, rx_take})
                2'b10:   rx_cnt <= rx_cnt + cw'(1);
                2'b01:   rx_cnt <= rx_cnt - cw'(1);
                default: rx_cnt <= rx_cnt;
            endcase
            if (rx_drop && rx_ovf_cnt != 8'hFF) begin
                rx_ovf_cnt <= rx_ovf_cnt + 8'd1;
            end
            if (rx_rej && rx_flt_cnt != 8'hFF) begin
                rx_flt_cnt <= rx_flt_cnt + 8'd1;
            end
        end
    end

endmodule

// File: tb/tb_bus_dev_port.sv
// tb/tb_bus_dev_port.sv - self-checking bench for bus_dev_port: directed vector table plus randomized queue-model comparison
module tb_bus_dev_port;

    logic        clk;
    logic        reset;
    logic        pop;
    logic        pndng;
    logic [15:0] D_pop;
    logic        push;
    logic [15:0] D_push;
    logic        tx_wr;
    logic [15:0] tx_data;
    logic        tx_full;
    logic        rx_rd;
    logic [15:0] rx_data;
    logic        rx_empty;
    logic [2:0]  tx_cnt;
    logic [2:0]  rx_cnt;
    logic [7:0]  tx_ovf_cnt;
    logic [7:0]  rx_ovf_cnt;
    logic [7:0]  rx_flt_cnt;
    logic        pop_err;

    int checks;
    int failures;

    bus_dev_port #(
        .pckg_sz(16), .depth(4), .id(8'h02), .broadcast(8'hFF)
    ) dut (
        .clk(clk), .reset(reset), .pop(pop), .pndng(pndng), .D_pop(D_pop),
        .push(push), .D_push(D_push), .tx_wr(tx_wr), .tx_data(tx_data),
        .tx_full(tx_full), .rx_rd(rx_rd), .rx_data(rx_data), .rx_empty(rx_empty),
        .tx_cnt(tx_cnt), .rx_cnt(rx_cnt), .tx_ovf_cnt(tx_ovf_cnt),
        .rx_ovf_cnt(rx_ovf_cnt), .rx_flt_cnt(rx_flt_cnt), .pop_err(pop_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: packet queues and plain integer counters
    logic [15:0] m_tx[$];
    logic [15:0] m_rx[$];
    int          m_txo;
    int          m_rxo;
    int          m_flt;
    bit          m_perr;

    task automatic model_reset();
        m_tx.delete();
        m_rx.delete();
        m_txo  = 0;
        m_rxo  = 0;
        m_flt  = 0;
        m_perr = 1'b0;
    endtask

    task automatic model_update(input logic wr, input logic [15:0] td, input logic p,
                                input logic ps, input logic [15:0] dp, input logic rd);
        bit tx_was_full;
        bit rx_was_full;
        tx_was_full = (m_tx.size() == 4);
        rx_was_full = (m_rx.size() == 4);
        if (p) begin
            if (m_tx.size() > 0) void'(m_tx.pop_front());
            else m_perr = 1'b1;
        end
        if (wr) begin
            if (!tx_was_full || p) m_tx.push_back(td);
            else if (m_txo < 255) m_txo++;
        end
        if (rd && m_rx.size() > 0) void'(m_rx.pop_front());
        if (ps) begin
            if (dp[15:8] == 8'h02 || dp[15:8] == 8'hFF) begin
                if (!rx_was_full || rd) m_rx.push_back(dp);
                else if (m_rxo < 255) m_rxo++;
            end else if (m_flt < 255) begin
                m_flt++;
            end
        end
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_model();
        chk("pndng",      32'(pndng),      32'(m_tx.size() != 0));
        chk("D_pop",      32'(D_pop),      (m_tx.size() != 0) ? 32'(m_tx[0]) : 32'd0);
        chk("tx_full",    32'(tx_full),    32'(m_tx.size() == 4));
        chk("tx_cnt",     32'(tx_cnt),     32'(m_tx.size()));
        chk("rx_empty",   32'(rx_empty),   32'(m_rx.size() == 0));
        chk("rx_data",    32'(rx_data),    (m_rx.size() != 0) ? 32'(m_rx[0]) : 32'd0);
        chk("rx_cnt",     32'(rx_cnt),     32'(m_rx.size()));
        chk("tx_ovf_cnt", 32'(tx_ovf_cnt), 32'(m_txo));
        chk("rx_ovf_cnt", 32'(rx_ovf_cnt), 32'(m_rxo));
        chk("rx_flt_cnt", 32'(rx_flt_cnt), 32'(m_flt));
        chk("pop_err",    32'(pop_err),    32'(m_perr));
    endtask

    // Inputs change one time unit after the rising edge; outputs are compared there too
    task automatic step(input logic wr, input logic [15:0] td, input logic p,
                        input logic ps, input logic [15:0] dp, input logic rd);
        tx_wr   = wr;
        tx_data = td;
        pop     = p;
        push    = ps;
        D_push  = dp;
        rx_rd   = rd;
        model_update(wr, td, p, ps, dp, rd);
        @(posedge clk);
        #1;
        compare_model();
    endtask

    task automatic idle();
        step(1'b0, 16'h0, 1'b0, 1'b0, 16'h0, 1'b0);
    endtask

    task automatic async_reset(input bit check_now);
        tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        model_reset();
        if (check_now) compare_model();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    typedef struct {
        logic        wr;
        logic [15:0] td;
        logic        p;
        logic        ps;
        logic [15:0] dp;
        logic        rd;
        logic [2:0]  e_tc;
        logic [15:0] e_dpop;
        logic [2:0]  e_rc;
        logic [15:0] e_rxd;
        logic [7:0]  e_txo;
        logic [7:0]  e_rxo;
        logic [7:0]  e_flt;
    } vec_t;

    vec_t vecs[25];

    initial begin
        checks   = 0;
        failures = 0;
        model_reset();
        reset = 1'b0; pop = 1'b0; push = 1'b0; D_push = '0;
        tx_wr = 1'b0; tx_data = '0; rx_rd = 1'b0;

        //           wr    td        pop   push  D_push    rd    tx_cnt D_pop     rx_cnt rx_data   txo   rxo   flt
        vecs[0]  = '{1'b1, 16'h0311, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd1, 16'h0311, 3'd0, 16'h0000, 8'd0, 8'd0, 8'd0};
        vecs[1]  = '{1'b1, 16'h0322, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd2, 16'h0311, 3'd0, 16'h0000, 8'd0, 8'd0, 8'd0};
        vecs[2]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd1, 16'h0322, 3'd0, 16'h0000, 8'd0, 8'd0, 8'd0};
        vecs[3]  = '{1'b0, 16'h0000, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd0, 16'h0000, 3'd0, 16'h0000, 8'd0, 8'd0, 8'd0};
        vecs[4]  = '{1'b1, 16'h0501, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd1, 16'h0501, 3'd0, 16'h0000, 8'd0, 8'd0, 8'd0};
        vecs[5]  = '{1'b1, 16'h0502, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd2, 16'h0501, 3'd0, 16'h0000, 8'd0, 8'd0, 8'd0};
        vecs[6]  = '{1'b1, 16'h0503, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd3, 16'h0501, 3'd0, 16'h0000, 8'd0, 8'd0, 8'd0};
        vecs[7]  = '{1'b1, 16'h0504, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd4, 16'h0501, 3'd0, 16'h0000, 8'd0, 8'd0, 8'd0};
        vecs[8]  = '{1'b1, 16'h0505, 1'b0, 1'b0, 16'h0000, 1'b0, 3'd4, 16'h0501, 3'd0, 16'h0000, 8'd1, 8'd0, 8'd0};
        vecs[9]  = '{1'b1, 16'h0506, 1'b1, 1'b0, 16'h0000, 1'b0, 3'd4, 16'h0502, 3'd0, 16'h0000, 8'd1, 8'd0, 8'd0};
        vecs[10] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h02AA, 1'b0, 3'd4, 16'h0502, 3'd1, 16'h02AA, 8'd1, 8'd0, 8'd0};
        vecs[11] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'hFFBB, 1'b0, 3'd4, 16'h0502, 3'd2, 16'h02AA, 8'd1, 8'd0, 8'd0};
        vecs[12] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h05CC, 1'b0, 3'd4, 16'h0502, 3'd2, 16'h02AA, 8'd1, 8'd0, 8'd1};
        vecs[13] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd4, 16'h0502, 3'd1, 16'hFFBB, 8'd1, 8'd0, 8'd1};
        vecs[14] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd4, 16'h0502, 3'd0, 16'h0000, 8'd1, 8'd0, 8'd1};
        vecs[15] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0211, 1'b0, 3'd4, 16'h0502, 3'd1, 16'h0211, 8'd1, 8'd0, 8'd1};
        vecs[16] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0222, 1'b0, 3'd4, 16'h0502, 3'd2, 16'h0211, 8'd1, 8'd0, 8'd1};
        vecs[17] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0233, 1'b0, 3'd4, 16'h0502, 3'd3, 16'h0211, 8'd1, 8'd0, 8'd1};
        vecs[18] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0244, 1'b0, 3'd4, 16'h0502, 3'd4, 16'h0211, 8'd1, 8'd0, 8'd1};
        vecs[19] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0255, 1'b0, 3'd4, 16'h0502, 3'd4, 16'h0211, 8'd1, 8'd1, 8'd1};
        vecs[20] = '{1'b0, 16'h0000, 1'b0, 1'b1, 16'h0266, 1'b1, 3'd4, 16'h0502, 3'd4, 16'h0222, 8'd1, 8'd1, 8'd1};
        vecs[21] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd4, 16'h0502, 3'd3, 16'h0233, 8'd1, 8'd1, 8'd1};
        vecs[22] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd4, 16'h0502, 3'd2, 16'h0244, 8'd1, 8'd1, 8'd1};
        vecs[23] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd4, 16'h0502, 3'd1, 16'h0266, 8'd1, 8'd1, 8'd1};
        vecs[24] = '{1'b0, 16'h0000, 1'b0, 1'b0, 16'h0000, 1'b1, 3'd4, 16'h0502, 3'd0, 16'h0000, 8'd1, 8'd1, 8'd1};

        repeat (2) @(posedge clk);
        #1;
        reset = 1'b1;
        compare_model();
        chk("reset_rx_empty", 32'(rx_empty), 32'd1);
        chk("reset_D_pop",    32'(D_pop),    32'd0);

        for (int i = 0; i < 25; i++) begin
            step(vecs[i].wr, vecs[i].td, vecs[i].p, vecs[i].ps, vecs[i].dp, vecs[i].rd);
            chk($sformatf("vec%0d_tx_cnt", i),     32'(tx_cnt),     32'(vecs[i].e_tc));
            chk($sformatf("vec%0d_D_pop", i),      32'(D_pop),      32'(vecs[i].e_dpop));
            chk($sformatf("vec%0d_rx_cnt", i),     32'(rx_cnt),     32'(vecs[i].e_rc));
            chk($sformatf("vec%0d_rx_data", i),    32'(rx_data),    32'(vecs[i].e_rxd));
            chk($sformatf("vec%0d_tx_ovf_cnt", i), 32'(tx_ovf_cnt), 32'(vecs[i].e_txo));
            chk($sformatf("vec%0d_rx_ovf_cnt", i), 32'(rx_ovf_cnt), 32'(vecs[i].e_rxo));
            chk($sformatf("vec%0d_rx_flt_cnt", i), 32'(rx_flt_cnt), 32'(vecs[i].e_flt));
        end

        // Pop on an empty TX queue sets a sticky error
        async_reset(1'b0);
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("perr_set",     32'(pop_err), 32'd1);
        chk("perr_tx_cnt",  32'(tx_cnt),  32'd0);
        step(1'b1, 16'h0401, 1'b0, 1'b0, 16'h0, 1'b0);
        idle();
        chk("perr_sticky",  32'(pop_err), 32'd1);
        chk("perr_D_pop",   32'(D_pop),   32'h0401);
        step(1'b1, 16'h0402, 1'b1, 1'b0, 16'h0, 1'b0);

        // Simultaneous write and pop on empty TX: write lands, pop is flagged
        async_reset(1'b0);
        step(1'b1, 16'h0433, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("wrpop_empty_cnt", 32'(tx_cnt),  32'd1);
        chk("wrpop_empty_err", 32'(pop_err), 32'd1);

        // Mid-cycle reset with traffic queued on both sides
        async_reset(1'b0);
        step(1'b1, 16'h0601, 1'b0, 1'b1, 16'h0201, 1'b0);
        step(1'b1, 16'h0602, 1'b0, 1'b1, 16'hFF02, 1'b0);
        step(1'b1, 16'h0603, 1'b0, 1'b1, 16'h0903, 1'b0);
        idle();
        tx_wr = 1'b0; pop = 1'b0; push = 1'b0; rx_rd = 1'b0;
        #2;
        reset = 1'b0;
        #1;
        chk("areset_pndng",    32'(pndng),      32'd0);
        chk("areset_rx_empty", 32'(rx_empty),   32'd1);
        chk("areset_tx_cnt",   32'(tx_cnt),     32'd0);
        chk("areset_rx_cnt",   32'(rx_cnt),     32'd0);
        chk("areset_flt",      32'(rx_flt_cnt), 32'd0);
        chk("areset_D_pop",    32'(D_pop),      32'd0);
        model_reset();
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(1'b1, 16'h0777, 1'b0, 1'b0, 16'h0, 1'b0);
        chk("post_reset_D_pop",  32'(D_pop),  32'h0777);
        chk("post_reset_tx_cnt", 32'(tx_cnt), 32'd1);
        step(1'b0, 16'h0, 1'b1, 1'b0, 16'h0, 1'b0);
        chk("post_reset_empty",  32'(pndng),  32'd0);

        // Randomized traffic against the queue model
        for (int n = 0; n < 3000; n++) begin
            logic        r_wr, r_p, r_ps, r_rd;
            logic [15:0] r_td, r_dp;
            logic [7:0]  hi;
            int          sel;
            r_wr = 1'($urandom_range(0, 1));
            r_p  = ($urandom_range(0, 2) == 0);
            r_ps = 1'($urandom_range(0, 1));
            r_rd = ($urandom_range(0, 2) == 0);
            r_td = 16'($urandom);
            sel  = $urandom_range(0, 3);
            case (sel)
                0:       hi = 8'h02;
                1:       hi = 8'hFF;
                default: hi = 8'($urandom);
            endcase
            r_dp = {hi, 8'($urandom)};
            if ($urandom_range(0, 499) == 0) async_reset(1'b1);
            else step(r_wr, r_td, r_p, r_ps, r_dp, r_rd);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
